// File: rtl/axil_req_arbiter.sv
// Two-requester AXI4-Lite master: arbitrates single-word commands and runs one transaction at a time.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
module axil_req_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [1:0]                        REQ_VALID,
    input  logic [1:0]                        REQ_WE,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
    output logic [1:0]                        REQ_DONE,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     REQ_RDATA,
    output logic [1:0]                        REQ_RESP,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    r_state;
    logic          r_grant;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;
    logic [1:0]    r_done;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_resp;

    logic          w_gnt;
    logic          w_aw_fin;
    logic          w_w_fin;

`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign w_gnt = ~REQ_VALID[0];
`else
    logic r_last_grant;
    assign w_gnt = (REQ_VALID == 2'b11) ? ~r_last_grant : ~REQ_VALID[0];
`endif

    // A write channel is finished once its VALID has dropped or it handshakes this cycle.
    assign w_aw_fin = ~r_awvalid | M_AXI_AWREADY;
    assign w_w_fin  = ~r_wvalid  | M_AXI_WREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= S_IDLE;
            r_grant   <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
            r_addr    <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= 2'b00;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (|REQ_VALID) begin
                        r_grant <= w_gnt;
`ifndef AXIL_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_gnt;
`endif
                        r_addr  <= w_gnt ? REQ_ADDR[2*AW-1:AW]  : REQ_ADDR[AW-1:0];
                        r_wdata <= w_gnt ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
                        if (REQ_WE[w_gnt]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_resp   <= M_AXI_BRESP;
                        r_done   <= r_grant ? 2'b10 : 2'b01;
                        r_state  <= S_DONE;
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        r_rdata  <= M_AXI_RDATA;
                        r_resp   <= M_AXI_RRESP;
                        r_done   <= r_grant ? 2'b10 : 2'b01;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign REQ_DONE      = r_done;
    assign REQ_RDATA     = r_rdata;
    assign REQ_RESP      = r_resp;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
